// File: rtl/prog_rom_pkg.sv
// prog_rom_pkg: shared types and sizing helpers for the program ROM.
//   state_t       - loader FSM states
//   depth()       - number of words for a given fetch address width
package prog_rom_pkg;

    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Words addressable by an aw-bit program counter.
    function automatic int unsigned depth(input int unsigned aw);
        return 32'(1) << aw;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// prog_loader: byte-stream load controller for the program ROM.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   load_start, load_abort    - begin / abandon a full program load
//   load_valid, load_data     - incoming program word stream
//   load_ready                - word accepted this cycle when valid (high in LOAD)
//   cpu_hold                  - CPU must stall (LOAD and DONE)
//   load_done                 - one-cycle pulse after the last word is written
//   load_sum                  - XOR of words written in the current/last load
//   we_c, waddr               - memory write strobe (combinational) and address
module prog_loader
    import prog_rom_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_abort,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [DATA_W-1:0] load_sum,
    output logic              we_c,
    output logic [ADDR_W-1:0] waddr
);

    localparam int unsigned DEPTH = depth(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] wptr;

    // load_ready mirrors state==LOAD, so abort gating is the only extra term.
    assign we_c  = load_valid & load_ready & ~load_abort;
    assign waddr = wptr;

    // FSM with registered outputs; each transition sets the outputs of its target state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wptr       <= '0;
            load_sum   <= '0;
            load_ready <= 1'b0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start && !load_abort) begin
                        state      <= LOAD;
                        wptr       <= '0;
                        load_sum   <= '0;
                        load_ready <= 1'b1;
                        cpu_hold   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_abort) begin
                        state      <= IDLE;
                        load_ready <= 1'b0;
                        cpu_hold   <= 1'b0;
                    end else if (load_valid) begin
                        load_sum <= load_sum ^ load_data;
                        // Wraps to 0 after the last index; no extra word is written.
                        wptr     <= wptr + ADDR_W'(1);
                        if (wptr == LAST_IDX) begin
                            state      <= DONE;
                            load_ready <= 1'b0;
                            load_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cpu_hold  <= 1'b0;
                    load_done <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    load_ready <= 1'b0;
                    cpu_hold   <= 1'b0;
                    load_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/prog_rom.sv
// prog_rom: run-time loadable program memory on the CPU fetch interface.
// Ports:
//   clk, rst          - clock, synchronous active-high reset (clears memory)
//   addr, data        - fetch address and zero-latency instruction word
//   load_start/abort  - begin / abandon a program load
//   load_valid/data   - program word stream, address order from 0
//   load_ready        - word accepted this cycle
//   cpu_hold          - CPU stall during load
//   load_done         - pulse after the last word is written
//   load_sum          - XOR of words written by the current/last load
module prog_rom
    import prog_rom_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    input  logic              load_start,
    input  logic              load_abort,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [DATA_W-1:0] load_sum
);

    localparam int unsigned DEPTH = depth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              we_c;
    logic [ADDR_W-1:0] waddr;

    prog_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_loader (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_abort (load_abort),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_sum   (load_sum),
        .we_c       (we_c),
        .waddr      (waddr)
    );

    // Memory array; reset clears every word so a partial load is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we_c) begin
            mem[waddr] <= load_data;
        end
    end

    // Combinational fetch: old word visible during its own write cycle.
    assign data = mem[addr];

endmodule

// File: tb/tb_prog_rom.sv
// tb_prog_rom: self-checking bench for prog_rom using a read scoreboard.
module tb_prog_rom;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              load_start;
    logic              load_abort;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              cpu_hold;
    logic              load_done;
    logic [DATA_W-1:0] load_sum;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] mem_m [DEPTH];
    logic [DATA_W-1:0] sum_m;
    int                wp_m;
    logic [DATA_W-1:0] sbq [$];

    int done_pulses;
    int ready_cycles;

    prog_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .data       (data),
        .load_start (load_start),
        .load_abort (load_abort),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_sum   (load_sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of load-port inputs, then return 1ns after the edge with inputs idle.
    task automatic cyc(input logic s, input logic a, input logic v, input logic [DATA_W-1:0] d);
        load_start = s;
        load_abort = a;
        load_valid = v;
        load_data  = d;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        load_abort = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
    endtask

    task automatic start_load();
        cyc(1'b1, 1'b0, 1'b0, '0);
        wp_m  = 0;
        sum_m = '0;
    endtask

    // Push one accepted word and update the reference model.
    task automatic put(input logic [DATA_W-1:0] d);
        cyc(1'b0, 1'b0, 1'b1, d);
        mem_m[wp_m] = d;
        sum_m       = sum_m ^ d;
        wp_m        = (wp_m + 1) % DEPTH;
    endtask

    // Scoreboarded read: expectation queued when addr is driven, compared when data settles.
    task automatic rd(input int a, input string tag);
        logic [DATA_W-1:0] exp;
        addr = ADDR_W'(a);
        sbq.push_back(mem_m[a]);
        #1;
        exp = sbq.pop_front();
        check(tag, 32'(data), 32'(exp));
    endtask

    task automatic readback(input string tag);
        for (int i = 0; i < int'(DEPTH); i++) begin
            rd(i, tag);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        rst = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;
        sum_m = '0;
        wp_m  = 0;
    endtask

    logic [DATA_W-1:0] w3 [DEPTH];

    initial begin
        rst        = 1'b0;
        addr       = '0;
        load_start = 1'b0;
        load_abort = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        w3 = '{4'h9, 4'h4, 4'h2, 4'h7, 4'hC, 4'h3, 4'hE, 4'h5,
               4'h8, 4'h1, 4'hB, 4'hD, 4'h0, 4'hA, 4'hF, 4'h6};

        // 1: reset state and all-zero memory
        do_reset();
        check("rst_hold", 32'(cpu_hold), 0);
        check("rst_ready", 32'(load_ready), 0);
        check("rst_done", 32'(load_done), 0);
        check("rst_sum", 32'(load_sum), 0);
        readback("rst_mem");

        // start+abort together in IDLE: stays idle
        cyc(1'b1, 1'b1, 1'b0, '0);
        check("sa_hold", 32'(cpu_hold), 0);
        check("sa_ready", 32'(load_ready), 0);

        // 2: straight load of 0..15
        check("t2_pre_hold", 32'(cpu_hold), 0);
        start_load();
        check("t2_hold_start", 32'(cpu_hold), 1);
        done_pulses  = 0;
        ready_cycles = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (load_ready) ready_cycles++;
            if (load_done) done_pulses++;
            check("t2_hold_mid", 32'(cpu_hold), 1);
            put(DATA_W'(i));
        end
        check("t2_ready_after", 32'(load_ready), 0);
        check("t2_hold_done", 32'(cpu_hold), 1);
        if (load_done) done_pulses++;
        cyc(1'b0, 1'b0, 1'b0, '0);
        if (load_done) done_pulses++;
        check("t2_ready_cycles", 32'(ready_cycles), 16);
        check("t2_done_pulses", 32'(done_pulses), 1);
        check("t2_hold_idle", 32'(cpu_hold), 0);
        check("t2_sum", 32'(load_sum), 32'(sum_m));
        check("t2_sum_const", 32'(load_sum), 0);
        readback("t2_mem");

        // 3: load with valid toggling; a stray load_start mid-load is ignored
        start_load();
        done_pulses = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            put(w3[i]);
            if (i < int'(DEPTH) - 1) begin
                if (load_done) done_pulses++;
                check("t3_ready_stall", 32'(load_ready), 1);
                cyc((i == 4) ? 1'b1 : 1'b0, 1'b0, 1'b0, 4'hF);
            end
        end
        if (load_done) done_pulses++;
        cyc(1'b0, 1'b0, 1'b0, '0);
        check("t3_done_pulses", 32'(done_pulses), 1);
        check("t3_sum", 32'(load_sum), 32'(sum_m));
        readback("t3_mem");

        // 4: abort after 5 words, same cycle as a 6th valid word
        start_load();
        for (int i = 0; i < 5; i++) put(4'h6);
        cyc(1'b0, 1'b1, 1'b1, 4'h1);
        check("t4_hold", 32'(cpu_hold), 0);
        check("t4_ready", 32'(load_ready), 0);
        check("t4_done", 32'(load_done), 0);
        check("t4_sum", 32'(load_sum), 32'h6);
        cyc(1'b0, 1'b0, 1'b0, '0);
        check("t4_done_late", 32'(load_done), 0);
        check("t4_mem5_prior", 32'(mem_m[5]), 32'(w3[5]));
        readback("t4_mem");

        // 5: write-through timing at a held address
        start_load();
        for (int i = 0; i < int'(DEPTH); i++) put((i == 3) ? 4'h1 : DATA_W'(15 - i));
        cyc(1'b0, 1'b0, 1'b0, '0);
        start_load();
        for (int i = 0; i < 3; i++) put(DATA_W'(i + 2));
        addr       = 4'd3;
        load_valid = 1'b1;
        load_data  = 4'hA;
        sbq.push_back(4'h1);
        #1;
        check("t5_old", 32'(data), 32'(sbq.pop_front()));
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_data  = '0;
        mem_m[3] = 4'hA;
        sum_m    = sum_m ^ 4'hA;
        wp_m     = 4;
        sbq.push_back(4'hA);
        check("t5_new", 32'(data), 32'(sbq.pop_front()));
        for (int i = 4; i < int'(DEPTH); i++) put(DATA_W'(i * 3));
        check("t5_done", 32'(load_done), 1);
        cyc(1'b0, 1'b0, 1'b0, '0);
        check("t5_sum", 32'(load_sum), 32'(sum_m));
        readback("t5_mem");

        // 6: reset mid-load clears memory; next load restarts at word 0
        start_load();
        for (int i = 0; i < 8; i++) put(DATA_W'(i + 7));
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 4'hC);
        rst = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;
        check("t6_hold", 32'(cpu_hold), 0);
        check("t6_ready", 32'(load_ready), 0);
        check("t6_sum", 32'(load_sum), 0);
        readback("t6_mem");
        start_load();
        put(4'h5);
        cyc(1'b0, 1'b1, 1'b0, '0);
        check("t6_sum2", 32'(load_sum), 32'h5);
        check("t6_hold2", 32'(cpu_hold), 0);
        readback("t6_reload");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
